// File: rtl/dbg_dispatch_pkg.sv
// Shared types for the debug command dispatcher: action opcodes, FSM states,
// sticky-flag bit positions and the opcode decode helper.
package dbg_dispatch_pkg;

   typedef enum logic [1:0] {
      NO_ACTION = 2'b00,
      ACTION_A  = 2'b01,
      ACTION_B  = 2'b10
   } act_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_e;

   localparam int FLAG_OVERRUN = 0;
   localparam int FLAG_BAD_SEL = 1;
   localparam int FLAG_TIMEOUT = 2;
   localparam int FLAG_W       = 3;

   // F1 has priority over F0; opcode 2'b11 is never produced.
   function automatic act_op_e decode_op(input logic f1, input logic f0);
      if (f1)      return ACTION_B;
      else if (f0) return ACTION_A;
      return NO_ACTION;
   endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level followed by a registered
// rising-edge detector producing a single clk-cycle pulse.
module dbg_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic pulse_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              pulse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], async_i};
         prev_q  <= sync_q[STAGES-1];
         pulse_q <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_cmd_dispatch.sv
// Sysclk-side JTAG debug command dispatcher: syncs update-IR/DR, captures jdo,
// decodes and hands the action to one of NUM_CORES debug modules.
// Optional ack timeout enabled by defining DBG_DISPATCH_TIMEOUT_EN.
module dbg_cmd_dispatch
   import dbg_dispatch_pkg::*;
#(
   parameter  int NUM_CORES   = 6,
   parameter  int DATA_W      = 38,
   parameter  int IR_W        = 2,
   parameter  int SYNC_STAGES = 2,
   parameter  int TIMEOUT_CYC = 1024,
   localparam int CSEL_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 vs_uir,
   input  logic                 vs_udr,
   input  logic [IR_W-1:0]      ir_in,
   input  logic [DATA_W-1:0]    sr,
   input  logic [CSEL_W-1:0]    core_sel,
   input  logic                 err_clr,
   input  logic [NUM_CORES-1:0] core_ack,
   output logic [DATA_W-1:0]    jdo,
   output logic [NUM_CORES-1:0] act_valid,
   output logic [IR_W-1:0]      act_ir,
   output logic [1:0]           act_op,
   output logic                 st_busy,
   output logic                 err_overrun,
   output logic                 err_bad_sel,
   output logic                 err_timeout
);

   logic [1:0] vs_raw;
   logic [1:0] vs_pulse;
   logic       uir_pulse;
   logic       udr_pulse;

   assign vs_raw = {vs_udr, vs_uir};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      dbg_sync_edge #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .rst_n   (reset_n),
         .async_i (vs_raw[gi]),
         .pulse_o (vs_pulse[gi])
      );
   end

   assign uir_pulse = vs_pulse[0];
   assign udr_pulse = vs_pulse[1];

   state_e                state_q,     state_d;
   logic [DATA_W-1:0]     jdo_q,       jdo_d;
   logic [CSEL_W-1:0]     csel_q,      csel_d;
   logic [IR_W-1:0]       ir_q,        ir_d;
   logic [IR_W-1:0]       act_ir_q,    act_ir_d;
   act_op_e               act_op_q,    act_op_d;
   logic [NUM_CORES-1:0]  act_valid_q, act_valid_d;
   logic [FLAG_W-1:0]     err_q,       err_d;
   logic [FLAG_W-1:0]     err_set;
   logic                  ack_hit;
   logic                  sel_bad;

`ifdef DBG_DISPATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] cnt_q, cnt_d;
`endif

   // act_valid is one-hot on csel_q while waiting, so masking suffices to
   // ignore acks from non-selected cores.
   assign ack_hit = |(core_ack & act_valid_q);
   assign sel_bad = (int'(csel_q) >= NUM_CORES);

   always_comb begin
      state_d     = state_q;
      jdo_d       = jdo_q;
      csel_d      = csel_q;
      ir_d        = uir_pulse ? ir_in : ir_q;
      act_ir_d    = act_ir_q;
      act_op_d    = act_op_q;
      act_valid_d = act_valid_q;
      err_set     = '0;
`ifdef DBG_DISPATCH_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (udr_pulse) begin
               jdo_d   = sr;
               csel_d  = core_sel;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            err_set[FLAG_OVERRUN] = udr_pulse;
            if (sel_bad) begin
               err_set[FLAG_BAD_SEL] = 1'b1;
               state_d               = IDLE;
            end else begin
               act_valid_d = NUM_CORES'(1) << csel_q;
               act_op_d    = decode_op(jdo_q[DATA_W-1], jdo_q[DATA_W-2]);
               act_ir_d    = ir_q;
               state_d     = WAIT;
`ifdef DBG_DISPATCH_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         WAIT: begin
            err_set[FLAG_OVERRUN] = udr_pulse;
            if (ack_hit) begin
               act_valid_d = '0;
               state_d     = IDLE;
            end
`ifdef DBG_DISPATCH_TIMEOUT_EN
            else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               act_valid_d           = '0;
               err_set[FLAG_TIMEOUT] = 1'b1;
               state_d               = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      // A flag raised in the same cycle as err_clr survives the clear.
      err_d = err_set | (err_q & ~{FLAG_W{err_clr}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         jdo_q       <= '0;
         csel_q      <= '0;
         ir_q        <= '0;
         act_ir_q    <= '0;
         act_op_q    <= NO_ACTION;
         act_valid_q <= '0;
         err_q       <= '0;
`ifdef DBG_DISPATCH_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         jdo_q       <= jdo_d;
         csel_q      <= csel_d;
         ir_q        <= ir_d;
         act_ir_q    <= act_ir_d;
         act_op_q    <= act_op_d;
         act_valid_q <= act_valid_d;
         err_q       <= err_d;
`ifdef DBG_DISPATCH_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign jdo         = jdo_q;
   assign act_valid   = act_valid_q;
   assign act_ir      = act_ir_q;
   assign act_op      = act_op_q;
   assign st_busy     = (state_q != IDLE);
   assign err_overrun = err_q[FLAG_OVERRUN];
   assign err_bad_sel = err_q[FLAG_BAD_SEL];
   // Never set unless the timeout path is compiled in.
   assign err_timeout = err_q[FLAG_TIMEOUT];

endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// Self-checking bench for dbg_cmd_dispatch: directed scenarios plus randomized
// commands checked against a rule-level model of the dispatcher.
module tb_dbg_cmd_dispatch;

   localparam int NC = 6;
   localparam int DW = 38;
   localparam int IW = 2;
   localparam int SS = 2;
   localparam int TO = 16;
   localparam int CW = 3;

   logic          clk;
   logic          reset_n;
   logic          vs_uir;
   logic          vs_udr;
   logic [IW-1:0] ir_in;
   logic [DW-1:0] sr;
   logic [CW-1:0] core_sel;
   logic          err_clr;
   logic [NC-1:0] core_ack;
   logic [DW-1:0] jdo;
   logic [NC-1:0] act_valid;
   logic [IW-1:0] act_ir;
   logic [1:0]    act_op;
   logic          st_busy;
   logic          err_overrun;
   logic          err_bad_sel;
   logic          err_timeout;

   int checks = 0;
   int errors = 0;
   logic [IW-1:0] ir_model;

   dbg_cmd_dispatch #(
      .NUM_CORES   (NC),
      .DATA_W      (DW),
      .IR_W        (IW),
      .SYNC_STAGES (SS),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vs_uir      (vs_uir),
      .vs_udr      (vs_udr),
      .ir_in       (ir_in),
      .sr          (sr),
      .core_sel    (core_sel),
      .err_clr     (err_clr),
      .core_ack    (core_ack),
      .jdo         (jdo),
      .act_valid   (act_valid),
      .act_ir      (act_ir),
      .act_op      (act_op),
      .st_busy     (st_busy),
      .err_overrun (err_overrun),
      .err_bad_sel (err_bad_sel),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rules: opcode from the two MSBs, one-hot target if in range.
   function automatic logic [1:0] exp_op(input logic [DW-1:0] s);
      if (s[DW-1])      return 2'd2;
      else if (s[DW-2]) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [NC-1:0] exp_valid(input logic [CW-1:0] sel);
      logic [NC-1:0] v;
      v = '0;
      if (int'(sel) < NC) v[sel] = 1'b1;
      return v;
   endfunction

   function automatic logic [DW-1:0] rand_sr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // Raise vs_udr (and optionally vs_uir) and return at the negedge of E+1.
   task automatic send_udr(input logic [DW-1:0] s, input logic [CW-1:0] sel,
                           input logic with_uir, input logic [IW-1:0] ir);
      sr       = s;
      core_sel = sel;
      vs_udr   = 1'b1;
      if (with_uir) begin
         ir_in  = ir;
         vs_uir = 1'b1;
      end
      repeat (SS + 2) @(negedge clk);
      vs_udr = 1'b0;
      vs_uir = 1'b0;
   endtask

   task automatic send_uir(input logic [IW-1:0] ir);
      ir_in  = ir;
      vs_uir = 1'b1;
      repeat (SS + 2) @(negedge clk);
      vs_uir = 1'b0;
      repeat (SS + 1) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      if (jdo !== '0) begin errors++; $display("FAIL rst_jdo got %h want 0", jdo); end checks++;
      if (act_valid !== '0) begin errors++; $display("FAIL rst_valid got %b want 0", act_valid); end checks++;
      if (act_op !== 2'd0 || act_ir !== '0) begin errors++; $display("FAIL rst_op_ir got %b/%b want 0/0", act_op, act_ir); end checks++;
      if (st_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", st_busy); end checks++;
      if ({err_overrun, err_bad_sel, err_timeout} !== 3'b000) begin errors++; $display("FAIL rst_err got %b want 000", {err_overrun, err_bad_sel, err_timeout}); end checks++;
      reset_n  = 1'b1;
      ir_model = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [DW-1:0] s;
      s = rand_sr();
      s[DW-1:DW-2] = 2'b01;
      send_uir(2'b10);
      ir_model = 2'b10;
      send_udr(s, 3'd3, 1'b0, '0);
      if (jdo !== s) begin errors++; $display("FAIL basic_jdo got %h want %h", jdo, s); end checks++;
      if (act_valid !== '0 || st_busy !== 1'b1) begin errors++; $display("FAIL basic_e1 got valid %b busy %b want 0 1", act_valid, st_busy); end checks++;
      @(negedge clk);
      if (act_valid !== 6'b001000) begin errors++; $display("FAIL basic_valid got %b want 001000", act_valid); end checks++;
      if (act_op !== 2'b01 || act_ir !== 2'b10) begin errors++; $display("FAIL basic_op_ir got %b/%b want 01/10", act_op, act_ir); end checks++;
      core_ack = 6'b110111;
      @(negedge clk);
      if (act_valid !== 6'b001000) begin errors++; $display("FAIL basic_ignore_ack got %b want 001000", act_valid); end checks++;
      core_ack = '0;
      @(negedge clk);
      if (act_valid !== 6'b001000) begin errors++; $display("FAIL basic_e4 got %b want 001000", act_valid); end checks++;
      core_ack = 6'b001000;
      @(negedge clk);
      core_ack = '0;
      if (act_valid !== '0) begin errors++; $display("FAIL basic_ack got %b want 0", act_valid); end checks++;
      @(negedge clk);
      if (st_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", st_busy); end checks++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ack_high();
      logic [DW-1:0] s;
      s = rand_sr();
      s[DW-1] = 1'b1;
      core_ack = '1;
      send_udr(s, 3'd0, 1'b0, '0);
      @(negedge clk);
      if (act_valid !== 6'b000001 || act_op !== 2'b10) begin errors++; $display("FAIL ackhi_e2 got %b op %b want 000001 op 10", act_valid, act_op); end checks++;
      @(negedge clk);
      if (act_valid !== '0) begin errors++; $display("FAIL ackhi_e3 got %b want 0", act_valid); end checks++;
      core_ack = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_bad_sel();
      send_udr(rand_sr(), 3'd7, 1'b0, '0);
      if (st_busy !== 1'b1) begin errors++; $display("FAIL badsel_e1 got busy %b want 1", st_busy); end checks++;
      @(negedge clk);
      if (act_valid !== '0 || st_busy !== 1'b0) begin errors++; $display("FAIL badsel_e2 got valid %b busy %b want 0 0", act_valid, st_busy); end checks++;
      if (err_bad_sel !== 1'b1) begin errors++; $display("FAIL badsel_flag got %b want 1", err_bad_sel); end checks++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      if (err_bad_sel !== 1'b0) begin errors++; $display("FAIL badsel_clr got %b want 0", err_bad_sel); end checks++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [DW-1:0] s1;
      s1 = rand_sr();
      send_udr(s1, 3'd2, 1'b0, '0);
      repeat (3) @(negedge clk);
      send_udr(~s1, 3'd4, 1'b0, '0);
      if (jdo !== s1) begin errors++; $display("FAIL ovr_jdo got %h want %h", jdo, s1); end checks++;
      if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", err_overrun); end checks++;
      if (act_valid !== 6'b000100) begin errors++; $display("FAIL ovr_valid got %b want 000100", act_valid); end checks++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", err_overrun); end checks++;
      core_ack = 6'b000100;
      @(negedge clk);
      core_ack = '0;
      if (act_valid !== '0) begin errors++; $display("FAIL ovr_ack got %b want 0", act_valid); end checks++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random(input int n);
      logic [DW-1:0] s;
      logic [CW-1:0] sel;
      logic [IW-1:0] ir;
      logic          do_uir;
      logic [NC-1:0] ev;
      int            dly;
      for (int i = 0; i < n; i++) begin
         s      = rand_sr();
         sel    = CW'($urandom_range(0, 7));
         ir     = IW'($urandom_range(0, 3));
         do_uir = 1'($urandom_range(0, 1));
         dly    = $urandom_range(0, 3);
         if (do_uir) ir_model = ir;
         ev = exp_valid(sel);
         $display("cmd %0d sel %0d uir %0d ir %0d op %0d ack_dly %0d", i, sel, do_uir, ir_model, exp_op(s), dly);
         send_udr(s, sel, do_uir, ir);
         if (jdo !== s) begin errors++; $display("FAIL rnd_jdo[%0d] got %h want %h", i, jdo, s); end checks++;
         @(negedge clk);
         if (act_valid !== ev) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, act_valid, ev); end checks++;
         if (ev != '0) begin
            if (act_op !== exp_op(s) || act_ir !== ir_model) begin errors++; $display("FAIL rnd_op_ir[%0d] got %b/%b want %b/%b", i, act_op, act_ir, exp_op(s), ir_model); end checks++;
            for (int d = 0; d < dly; d++) begin
               core_ack = NC'($urandom()) & ~ev;
               @(negedge clk);
               if (act_valid !== ev) begin errors++; $display("FAIL rnd_hold[%0d] got %b want %b", i, act_valid, ev); end checks++;
            end
            core_ack = ev | NC'($urandom());
            @(negedge clk);
            core_ack = '0;
            if (act_valid !== '0) begin errors++; $display("FAIL rnd_ack[%0d] got %b want 0", i, act_valid); end checks++;
         end else begin
            if (err_bad_sel !== 1'b1 || st_busy !== 1'b0) begin errors++; $display("FAIL rnd_badsel[%0d] got flag %b busy %b want 1 0", i, err_bad_sel, st_busy); end checks++;
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
         end
         repeat (3) @(negedge clk);
      end
   endtask

`ifdef DBG_DISPATCH_TIMEOUT_EN
   task automatic test_timeout();
      send_udr(rand_sr(), 3'd1, 1'b0, '0);
      repeat (TO) @(negedge clk);
      if (act_valid !== 6'b000010) begin errors++; $display("FAIL to_before got %b want 000010", act_valid); end checks++;
      @(negedge clk);
      if (act_valid !== '0 || err_timeout !== 1'b1) begin errors++; $display("FAIL to_drop got valid %b flag %b want 0 1", act_valid, err_timeout); end checks++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid_wait();
      logic [DW-1:0] s;
      send_udr(rand_sr(), 3'd5, 1'b0, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      if (act_valid !== '0 || st_busy !== 1'b0) begin errors++; $display("FAIL rmw_valid got %b busy %b want 0 0", act_valid, st_busy); end checks++;
      if (jdo !== '0 || act_op !== 2'd0 || act_ir !== '0) begin errors++; $display("FAIL rmw_regs got %h/%b/%b want 0", jdo, act_op, act_ir); end checks++;
      @(negedge clk);
      reset_n  = 1'b1;
      ir_model = '0;
      repeat (2) @(negedge clk);
      s = rand_sr();
      send_udr(s, 3'd5, 1'b0, '0);
      @(negedge clk);
      if (act_valid !== 6'b100000 || act_op !== exp_op(s) || act_ir !== ir_model) begin errors++; $display("FAIL rmw_fresh got %b op %b ir %b want 100000 op %b ir %b", act_valid, act_op, act_ir, exp_op(s), ir_model); end checks++;
      core_ack = 6'b100000;
      @(negedge clk);
      core_ack = '0;
      if (act_valid !== '0) begin errors++; $display("FAIL rmw_ack got %b want 0", act_valid); end checks++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      vs_uir   = 1'b0;
      vs_udr   = 1'b0;
      ir_in    = '0;
      sr       = '0;
      core_sel = '0;
      err_clr  = 1'b0;
      core_ack = '0;
      ir_model = '0;
      test_reset();
      test_basic();
      test_ack_high();
      test_bad_sel();
      test_overrun();
      test_random(24);
`ifdef DBG_DISPATCH_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbg_cmd_dispatch.md
# dbg_cmd_dispatch

Parametrised system-clock-side JTAG debug command dispatcher for multi-core Nios builds. It sits behind the virtual-JTAG TCK-domain shift logic and replaces the per-CPU sysclk decode stage. It synchronises the update-IR and update-DR strobes, captures the shifted data register, decodes it into an action, and delivers that action to one of NUM_CORES debug modules over a valid/ack handshake, with error flags for overrun and bad core select.

## Interface
- NUM_CORES, 6: number of target debug modules (1..16).
- DATA_W, 38: shift-register / jdo width (≥ 4).
- IR_W, 2: virtual IR width (≥ 2).
- SYNC_STAGES, 2: synchroniser depth for vs_uir/vs_udr (≥ 2).
- TIMEOUT_CYC, 1024: ack timeout in clk cycles (used only with the timeout feature).
- CSEL_W = max(1, $clog2(NUM_CORES)): derived localparam, not overridable.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- vs_uir  in  1  update-IR level from TCK domain; asynchronous to clk.
- vs_udr  in  1  update-DR level from TCK domain; asynchronous to clk.
- ir_in  in  IR_W  virtual IR, quasi-static around vs_uir.
- sr  in  DATA_W  shift register, quasi-static around vs_udr.
- core_sel  in  CSEL_W  target core, quasi-static around vs_udr.
- err_clr  in  1  clears sticky error flags.
- core_ack  in  NUM_CORES  per-core acceptance of the presented action.
- jdo  out  DATA_W  captured data register.
- act_valid  out  NUM_CORES  one-hot: action pending for that core.
- act_ir  out  IR_W  IR value for the action.
- act_op  out  2  00 NO_ACTION, 01 ACTION_A, 10 ACTION_B, 11 reserved (never driven).
- st_busy  out  1  high in any state other than IDLE.
- err_overrun  out  1  sticky.
- err_bad_sel  out  1  sticky.
- err_timeout  out  1  sticky; tied 0 when the timeout feature is compiled out.

## Operation
- Reset values: all outputs 0; ir_q 0; FSM IDLE.
- vs_uir and vs_udr each pass through a SYNC_STAGES flop chain followed by a rising-edge detect. A pulse is one clk cycle.
- uir pulse: ir_q <= ir_in. Accepted in every state.
- udr pulse in IDLE: jdo <= sr, csel_q <= core_sel. Go to ISSUE.
- Decode in ISSUE, with F1 = jdo[DATA_W-1] and F0 = jdo[DATA_W-2]: F1=1 gives ACTION_B; F1=0,F0=1 gives ACTION_A; F1=0,F0=0 gives NO_ACTION. act_ir = ir_q.
- ISSUE:
  - If csel_q ≥ NUM_CORES: set err_bad_sel, return to IDLE, no act_valid.
  - Otherwise assert act_valid[csel_q] and go to WAIT.
- WAIT:
  - act_valid, act_ir, act_op and jdo are held stable.
  - core_ack[csel_q] high: clear act_valid and go to IDLE in the same edge.
  - core_ack bits of non-selected cores are ignored.
- udr pulse in ISSUE or WAIT: command dropped, jdo unchanged, err_overrun set.
- Simultaneous uir and udr pulse in IDLE: jdo captures normally; ir_q takes the new ir_in, and the decode uses the new ir_q.
- err_clr: clears all sticky flags. A flag set in the same cycle as err_clr wins (stays set).
- Asynchronous reset mid-WAIT drops the pending action immediately.

## Timing
- Let cycle E be the cycle where the udr edge-detect pulse is high (SYNC_STAGES+1 clk edges after vs_udr rises and is stable).
- jdo is valid from E+1.
- act_valid rises at E+2 (ISSUE occupies E+1).
- Ack sampled high at cycle A: act_valid low at A+1; a new udr pulse is accepted from A+1.
- Minimum command spacing is 3 clk cycles plus ack latency.
- st_busy is high from E+1 until the cycle after ack.

## Configuration
- DBG_DISPATCH_TIMEOUT_EN defined:
  - WAIT runs a $clog2(TIMEOUT_CYC+1)-bit counter, cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC without ack: drop act_valid, set err_timeout, go to IDLE.
- Not defined: no counter; WAIT persists until ack or reset; err_timeout is constant 0.

## Structure
- Package dbg_dispatch_pkg holds:
  - act_op_e enum (NO_ACTION, ACTION_A, ACTION_B).
  - state_e enum (IDLE, ISSUE, WAIT).
  - Flag bit-offset constants.
- Sub-module dbg_sync_edge: SYNC_STAGES-deep synchroniser plus rising-edge pulse, instantiated twice.

## Test plan
- Reset then vs_uir with ir_in=2'b10, then vs_udr with sr[37:36]=2'b01, core_sel=3 -> act_valid=6'b001000, act_op=01, act_ir=10 at E+2; ack at E+4 -> act_valid=0 at E+5.
- sr[37]=1, core_sel=0, ack tied high -> act_op=10, act_valid[0] high for exactly one cycle.
- core_sel=7 with NUM_CORES=6 -> act_valid stays 0, err_bad_sel=1, st_busy returns to 0 at E+2.
- Second vs_udr during WAIT with different sr -> jdo unchanged, err_overrun=1; err_clr -> flag 0 next cycle.
- With DBG_DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=16, no ack -> act_valid drops after 16 WAIT cycles, err_timeout=1.
- reset_n low while in WAIT -> all outputs 0 immediately; a fresh command after release is handled normally.
